up_bus_resp_agg: RTL and testbench
==================================

# up_bus_resp_agg

Response aggregator and timeout guard for the internal up register bus. It sits directly downstream of the AXI-lite-to-up bridge and upstream of the register slaves (channel and common-control banks), all in the up_clk domain. It merges the slaves' rdata/rack/wack into one registered response. If no slave answers within a bounded time, it issues a synthetic response so the AXI master never hangs.

## Interface
- NUM_SLAVES, 3, number of up bus slaves merged
- TIMEOUT_CYCLES, 64, cycles from request to synthetic ack (range 2..65535)
- TIMEOUT_RDATA, 32'hDEAD_DEAD, read data returned on a read timeout
- ADDR_WIDTH, 14, up bus address width
- up_clk  in  1  register bus clock
- up_rstn  in  1  reset, asynchronous, active-low
- up_wreq  in  1  write request pulse from the bridge
- up_waddr  in  ADDR_WIDTH  write address
- up_rreq  in  1  read request pulse from the bridge
- up_raddr  in  ADDR_WIDTH  read address
- slv_wack  in  NUM_SLAVES  per-slave write ack
- slv_rack  in  NUM_SLAVES  per-slave read ack
- slv_rdata  in  32*NUM_SLAVES  per-slave read data, slave i at bits [32i+31:32i]
- up_wack  out  1  merged write ack to the bridge
- up_rack  out  1  merged read ack to the bridge
- up_rdata  out  32  merged read data
- up_status_clr  in  1  pulse; clears the statistics and sticky flags
- up_timeout_cnt  out  16  saturating count of timeouts (read + write)
- up_timeout_addr  out  ADDR_WIDTH  address of the most recent timeout
- up_timeout_rd  out  1  most recent timeout was a read (1) or a write (0)
- up_late_ack  out  1  sticky; a slave acked while no request was pending
- up_multi_ack  out  1  sticky; more than one slave acked in the same cycle

## Operation
- The read and write paths are independent. Each has its own two-state FSM: IDLE and WAIT.
- **IDLE:**
  - A request pulse moves the FSM to WAIT and clears the wait counter to 0.
  - The request address is captured.
- **WAIT, per cycle:**
  - If any slave acks: the merged ack is asserted the next cycle, and the FSM returns to IDLE.
  - Else, if the counter equals TIMEOUT_CYCLES-1: a synthetic ack is asserted the next cycle, and the FSM returns to IDLE. The timeout count increments (saturating at 16'hFFFF), and up_timeout_addr and up_timeout_rd are loaded.
  - Otherwise, the counter increments.
- **Read data:**
  - On a real ack, up_rdata is the OR of slv_rdata[i] gated by slv_rack[i].
  - On a read timeout, up_rdata is TIMEOUT_RDATA.
  - In every other cycle, up_rdata is 0.
- **Acks while IDLE:** slave acks are not forwarded and set up_late_ack.
- **Requests while in WAIT:** these are protocol violations. They are ignored, not queued, and do not restart the counter.
- **Multiple acks:** popcount(slv_rack) > 1 or popcount(slv_wack) > 1 in any cycle sets up_multi_ack. The read data is still the OR of the acking slaves.
- **Ack coinciding with timeout:** a real ack on the counter's terminal cycle wins. No timeout is recorded.
- **Read and write timeouts in the same cycle:** the count increments by 2 (saturating). The address and rd flag record the read.
- **up_status_clr:**
  - Zeroes the count, up_late_ack and up_multi_ack.
  - If an event occurs in the same cycle as the clear, the event is applied after the clear (count = 1, or the flag is set).
  - The clear does not affect the FSMs.

## Timing
- **Reset values:**
  - All outputs are 0.
  - Both FSMs start in IDLE.
  - Counters are 0.
- **Ack latency:**
  - A slave ack in cycle N produces up_rack/up_wack in cycle N+1, single-cycle, with up_rdata valid in the same cycle.
  - A request in cycle N with a slave ack in cycle N+1 produces the merged ack in cycle N+2.
- **Timeout latency:** a request in cycle N with no ack produces the synthetic ack in cycle N+TIMEOUT_CYCLES+1.
- **Back-to-back requests:** a new request is accepted in the same cycle that the previous merged ack is driven.
- **Reset mid-transaction:** the FSMs return to IDLE immediately and no ack is emitted.

## Configuration
- **UP_BUS_TIMEOUT_EN defined:**
  - The full behaviour above applies.
- **UP_BUS_TIMEOUT_EN undefined:**
  - There are no FSMs or counters.
  - up_rack, up_wack and up_rdata are the registered OR of the slave inputs, forwarded in any cycle.
  - up_timeout_cnt, up_timeout_addr, up_timeout_rd and up_late_ack are tied to 0.
  - up_multi_ack remains functional.

## Structure
- **Package up_bus_pkg:**
  - FSM state enum (IDLE, WAIT).
  - Default TIMEOUT_RDATA constant.
  - 16-bit counter saturation limit.
- **Sub-module up_bus_timeout_fsm:**
  - Request pulse, any-ack, terminal count, ack-out, timeout-pulse.
  - Instantiated once for read and once for write.
- The top level contains the data merge, statistics and sticky flags.

## Test plan
- **Normal read:** rreq with raddr=0x0010; slave 1 acks 3 cycles later with 32'h1234_5678. Required: one up_rack pulse, up_rdata=32'h1234_5678, timeout count unchanged.
- **Read timeout:** TIMEOUT_CYCLES=8; rreq with raddr=0x0ABC; no acks. Required: up_rack in cycle N+9 with up_rdata=32'hDEAD_DEAD, up_timeout_cnt=1, up_timeout_addr=0x0ABC, up_timeout_rd=1.
- **Late ack after write timeout:** the write times out, then slave 0 pulses wack. Required: no up_wack forwarded, up_late_ack=1, up_timeout_rd=0.
- **Ack on the terminal cycle:** the slave acks exactly when the counter reaches TIMEOUT_CYCLES-1. Required: a real ack with the slave's data, up_timeout_cnt unchanged.
- **Multiple acks plus clear:** slaves 0 and 2 ack with 32'h0000_00F0 and 32'h0000_000F. Required: up_rdata=32'h0000_00FF, up_multi_ack=1. Then a clear pulse coincides with a new timeout. Required: up_timeout_cnt=1, up_multi_ack=0.
- **Reset mid-operation:** assert up_rstn low during a read WAIT. Required: all outputs 0, no spurious ack after release, and the next read completes normally.

Source files
------------

// File: rtl/up_bus_pkg.sv
// rtl/up_bus_pkg.sv - shared types and constants for the up bus response aggregator
package up_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } up_bus_state_e;

    localparam logic [31:0] UP_BUS_TIMEOUT_RDATA = 32'hDEAD_DEAD;
    localparam logic [15:0] UP_BUS_CNT_MAX       = 16'hFFFF;

endpackage

// File: rtl/up_bus_timeout_fsm.sv
// rtl/up_bus_timeout_fsm.sv - per-direction request tracker with bounded wait and synthetic ack
module up_bus_timeout_fsm
    import up_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic up_clk,
    input  logic up_rstn,
    input  logic req,
    input  logic any_ack,
    output logic busy,
    output logic ack_out,
    output logic timeout_pulse
);

    localparam logic [15:0] TERMINAL = 16'(TIMEOUT_CYCLES - 1);

    up_bus_state_e state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          ack_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ack_d         = 1'b0;
        timeout_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // a real ack on the terminal cycle takes priority over the timeout
                if (any_ack) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TERMINAL) begin
                    ack_d         = 1'b1;
                    timeout_pulse = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_out <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_out <= ack_d;
        end
    end

    assign busy = (state_q == WAIT);

endmodule

// File: rtl/up_bus_resp_agg.sv
// rtl/up_bus_resp_agg.sv - merges up bus slave responses; UP_BUS_TIMEOUT_EN adds the timeout guard and statistics
module up_bus_resp_agg
    import up_bus_pkg::*;
#(
    parameter int          NUM_SLAVES     = 3,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_RDATA  = UP_BUS_TIMEOUT_RDATA,
    parameter int          ADDR_WIDTH     = 14
) (
    input  logic                     up_clk,
    input  logic                     up_rstn,
    input  logic                     up_wreq,
    input  logic [ADDR_WIDTH-1:0]    up_waddr,
    input  logic                     up_rreq,
    input  logic [ADDR_WIDTH-1:0]    up_raddr,
    input  logic [NUM_SLAVES-1:0]    slv_wack,
    input  logic [NUM_SLAVES-1:0]    slv_rack,
    input  logic [32*NUM_SLAVES-1:0] slv_rdata,
    output logic                     up_wack,
    output logic                     up_rack,
    output logic [31:0]              up_rdata,
    input  logic                     up_status_clr,
    output logic [15:0]              up_timeout_cnt,
    output logic [ADDR_WIDTH-1:0]    up_timeout_addr,
    output logic                     up_timeout_rd,
    output logic                     up_late_ack,
    output logic                     up_multi_ack
);

    localparam logic [NUM_SLAVES-1:0] ONE = NUM_SLAVES'(1);

    logic [31:0] merged_rdata;
    logic        any_rack;
    logic        any_wack;
    logic        multi_now;

    always_comb begin
        merged_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slv_rack[i]) merged_rdata = merged_rdata | slv_rdata[32*i +: 32];
        end
    end

    assign any_rack  = |slv_rack;
    assign any_wack  = |slv_wack;
    // x & (x-1) is nonzero exactly when more than one bit is set
    assign multi_now = (|(slv_rack & (slv_rack - ONE))) | (|(slv_wack & (slv_wack - ONE)));

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) up_multi_ack <= 1'b0;
        else          up_multi_ack <= (up_multi_ack & ~up_status_clr) | multi_now;
    end

`ifdef UP_BUS_TIMEOUT_EN
    logic                  rd_busy, wr_busy;
    logic                  rd_to, wr_to;
    logic [ADDR_WIDTH-1:0] raddr_q, waddr_q;
    logic [1:0]            to_inc;
    logic [15:0]           cnt_base;
    logic [16:0]           cnt_sum;

    up_bus_timeout_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_fsm (
        .up_clk(up_clk), .up_rstn(up_rstn), .req(up_rreq), .any_ack(any_rack),
        .busy(rd_busy), .ack_out(up_rack), .timeout_pulse(rd_to)
    );

    up_bus_timeout_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_fsm (
        .up_clk(up_clk), .up_rstn(up_rstn), .req(up_wreq), .any_ack(any_wack),
        .busy(wr_busy), .ack_out(up_wack), .timeout_pulse(wr_to)
    );

    // the clear is applied first so an event in the same cycle still lands
    assign to_inc   = {1'b0, rd_to} + {1'b0, wr_to};
    assign cnt_base = up_status_clr ? 16'd0 : up_timeout_cnt;
    assign cnt_sum  = {1'b0, cnt_base} + {15'd0, to_inc};

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            raddr_q         <= '0;
            waddr_q         <= '0;
            up_rdata        <= '0;
            up_timeout_cnt  <= '0;
            up_timeout_addr <= '0;
            up_timeout_rd   <= 1'b0;
            up_late_ack     <= 1'b0;
        end else begin
            if (up_rreq && !rd_busy) raddr_q <= up_raddr;
            if (up_wreq && !wr_busy) waddr_q <= up_waddr;

            if (rd_busy && any_rack) up_rdata <= merged_rdata;
            else if (rd_to)          up_rdata <= TIMEOUT_RDATA;
            else                     up_rdata <= '0;

            up_timeout_cnt <= cnt_sum[16] ? UP_BUS_CNT_MAX : cnt_sum[15:0];

            if (rd_to) begin
                up_timeout_addr <= raddr_q;
                up_timeout_rd   <= 1'b1;
            end else if (wr_to) begin
                up_timeout_addr <= waddr_q;
                up_timeout_rd   <= 1'b0;
            end

            up_late_ack <= (up_late_ack & ~up_status_clr)
                         | (any_rack & ~rd_busy) | (any_wack & ~wr_busy);
        end
    end
`else
    logic unused_cfg;

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_rack  <= 1'b0;
            up_wack  <= 1'b0;
            up_rdata <= '0;
        end else begin
            up_rack  <= any_rack;
            up_wack  <= any_wack;
            up_rdata <= merged_rdata;
        end
    end

    assign up_timeout_cnt  = '0;
    assign up_timeout_addr = '0;
    assign up_timeout_rd   = 1'b0;
    assign up_late_ack     = 1'b0;
    assign unused_cfg      = ^{up_wreq, up_waddr, up_rreq, up_raddr, TIMEOUT_RDATA, 16'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_up_bus_resp_agg.sv
// tb/tb_up_bus_resp_agg.sv - directed self-checking bench for up_bus_resp_agg
module tb_up_bus_resp_agg;

    localparam int NS = 3;
    localparam int AW = 14;

    logic          up_clk = 1'b0;
    logic          up_rstn;
    logic          up_wreq, up_rreq;
    logic [AW-1:0] up_waddr, up_raddr;
    logic [NS-1:0] slv_wack, slv_rack;
    logic [32*NS-1:0] slv_rdata;
    logic          up_wack, up_rack;
    logic [31:0]   up_rdata;
    logic          up_status_clr;
    logic [15:0]   up_timeout_cnt;
    logic [AW-1:0] up_timeout_addr;
    logic          up_timeout_rd, up_late_ack, up_multi_ack;

    int total = 0;
    int bad   = 0;
    int racks = 0;
    int wacks = 0;

    up_bus_resp_agg #(
        .NUM_SLAVES(NS), .TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEAD_DEAD), .ADDR_WIDTH(AW)
    ) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_rreq(up_rreq), .up_raddr(up_raddr),
        .slv_wack(slv_wack), .slv_rack(slv_rack), .slv_rdata(slv_rdata),
        .up_wack(up_wack), .up_rack(up_rack), .up_rdata(up_rdata),
        .up_status_clr(up_status_clr), .up_timeout_cnt(up_timeout_cnt),
        .up_timeout_addr(up_timeout_addr), .up_timeout_rd(up_timeout_rd),
        .up_late_ack(up_late_ack), .up_multi_ack(up_multi_ack)
    );

    always #5 up_clk = ~up_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge up_clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            racks += int'(up_rack);
            wacks += int'(up_wack);
            tick();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rack"},  32'(up_rack),         32'd0);
        chk({tag, "_wack"},  32'(up_wack),         32'd0);
        chk({tag, "_rdata"}, up_rdata,             32'd0);
        chk({tag, "_cnt"},   32'(up_timeout_cnt),  32'd0);
        chk({tag, "_addr"},  32'(up_timeout_addr), 32'd0);
        chk({tag, "_rd"},    32'(up_timeout_rd),   32'd0);
        chk({tag, "_late"},  32'(up_late_ack),     32'd0);
        chk({tag, "_multi"}, 32'(up_multi_ack),    32'd0);
    endtask

    initial begin
        up_rstn = 1'b0; up_wreq = 1'b0; up_rreq = 1'b0; up_waddr = '0; up_raddr = '0;
        slv_wack = '0; slv_rack = '0; slv_rdata = '0; up_status_clr = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        up_rstn = 1'b1;
        tick();

`ifdef UP_BUS_TIMEOUT_EN
        // normal read, slave 1 acks three cycles after the request
        up_rreq = 1'b1; up_raddr = 14'h0010; tick();
        up_rreq = 1'b0; racks = 0; run(2);
        slv_rack = 3'b010; slv_rdata[32 +: 32] = 32'h1234_5678; tick();
        slv_rack = '0;
        chk("rd_early",  32'(racks),          32'd0);
        chk("rd_ack",    32'(up_rack),        32'd1);
        chk("rd_data",   up_rdata,            32'h1234_5678);
        chk("rd_cnt",    32'(up_timeout_cnt), 32'd0);
        tick();
        chk("rd_single", 32'(up_rack),        32'd0);

        // read timeout with an ignored request mid-wait
        up_rreq = 1'b1; up_raddr = 14'h0ABC; tick();
        up_rreq = 1'b0; racks = 0; run(2);
        up_rreq = 1'b1; up_raddr = 14'h0FFF; run(1);
        up_rreq = 1'b0; run(5);
        chk("rto_early", 32'(racks),           32'd0);
        chk("rto_ack",   32'(up_rack),         32'd1);
        chk("rto_data",  up_rdata,             32'hDEAD_DEAD);
        chk("rto_cnt",   32'(up_timeout_cnt),  32'd1);
        chk("rto_addr",  32'(up_timeout_addr), 32'h0ABC);
        chk("rto_rd",    32'(up_timeout_rd),   32'd1);

        // write timeout followed by a late write ack
        up_wreq = 1'b1; up_waddr = 14'h0123; tick();
        up_wreq = 1'b0; wacks = 0; run(8);
        chk("wto_early", 32'(wacks),           32'd0);
        chk("wto_ack",   32'(up_wack),         32'd1);
        chk("wto_cnt",   32'(up_timeout_cnt),  32'd2);
        chk("wto_addr",  32'(up_timeout_addr), 32'h0123);
        chk("wto_rd",    32'(up_timeout_rd),   32'd0);
        chk("wto_rdata", up_rdata,             32'd0);
        chk("late_pre",  32'(up_late_ack),     32'd0);
        slv_wack = 3'b001; tick();
        slv_wack = '0;
        chk("late_fwd",  32'(up_wack),         32'd0);
        chk("late_flag", 32'(up_late_ack),     32'd1);

        // slave acks on the terminal count cycle
        up_rreq = 1'b1; up_raddr = 14'h0020; tick();
        up_rreq = 1'b0; racks = 0; run(7);
        slv_rack = 3'b001; slv_rdata[0 +: 32] = 32'hCAFE_0001; tick();
        slv_rack = '0;
        chk("term_early", 32'(racks),          32'd0);
        chk("term_ack",   32'(up_rack),        32'd1);
        chk("term_data",  up_rdata,            32'hCAFE_0001);
        chk("term_cnt",   32'(up_timeout_cnt), 32'd2);
        tick();
        chk("term_noto",  32'(up_rack),        32'd0);

        // two slaves ack together, then a back-to-back read
        up_rreq = 1'b1; up_raddr = 14'h0040; tick();
        up_rreq = 1'b0;
        slv_rack = 3'b101; slv_rdata[0 +: 32] = 32'h0000_00F0; slv_rdata[64 +: 32] = 32'h0000_000F; tick();
        slv_rack = '0;
        chk("multi_ack",   32'(up_rack),      32'd1);
        chk("multi_data",  up_rdata,          32'h0000_00FF);
        chk("multi_flag",  32'(up_multi_ack), 32'd1);
        up_rreq = 1'b1; up_raddr = 14'h0044; tick();
        up_rreq = 1'b0; slv_rack = 3'b010; slv_rdata[32 +: 32] = 32'h0000_0077; tick();
        slv_rack = '0;
        chk("b2b_ack",  32'(up_rack), 32'd1);
        chk("b2b_data", up_rdata,     32'h0000_0077);

        // clear coincides with a write timeout
        up_wreq = 1'b1; up_waddr = 14'h0200; tick();
        up_wreq = 1'b0; run(7);
        up_status_clr = 1'b1; tick();
        up_status_clr = 1'b0;
        chk("clr_wack",  32'(up_wack),        32'd1);
        chk("clr_cnt",   32'(up_timeout_cnt), 32'd1);
        chk("clr_multi", 32'(up_multi_ack),   32'd0);
        chk("clr_late",  32'(up_late_ack),    32'd0);

        // read and write time out in the same cycle
        up_rreq = 1'b1; up_raddr = 14'h0555; up_wreq = 1'b1; up_waddr = 14'h0666; tick();
        up_rreq = 1'b0; up_wreq = 1'b0; run(8);
        chk("dual_rack", 32'(up_rack),         32'd1);
        chk("dual_wack", 32'(up_wack),         32'd1);
        chk("dual_cnt",  32'(up_timeout_cnt),  32'd3);
        chk("dual_addr", 32'(up_timeout_addr), 32'h0555);
        chk("dual_rd",   32'(up_timeout_rd),   32'd1);

        // reset during a read wait
        up_rreq = 1'b1; up_raddr = 14'h0030; tick();
        up_rreq = 1'b0; tick(); tick();
        up_rstn = 1'b0; #1;
        chk_all_zero("mid_rst");
        tick(); tick();
        up_rstn = 1'b1; racks = 0; run(12);
        chk("rst_noack", 32'(racks), 32'd0);
        up_rreq = 1'b1; up_raddr = 14'h0030; tick();
        up_rreq = 1'b0; slv_rack = 3'b100; slv_rdata[64 +: 32] = 32'h5555_AAAA; tick();
        slv_rack = '0;
        chk("rst_rd_ack",  32'(up_rack), 32'd1);
        chk("rst_rd_data", up_rdata,     32'h5555_AAAA);
`else
        // forwarding mode: acks pass through a register without any request
        slv_rack = 3'b010; slv_rdata[32 +: 32] = 32'h1234_5678; tick();
        slv_rack = '0;
        chk("fwd_rack",  32'(up_rack), 32'd1);
        chk("fwd_rdata", up_rdata,     32'h1234_5678);
        tick();
        chk("fwd_rack0", 32'(up_rack), 32'd0);
        chk("fwd_data0", up_rdata,     32'd0);
        slv_wack = 3'b100; tick();
        slv_wack = '0;
        chk("fwd_wack",  32'(up_wack), 32'd1);
        chk("fwd_wrack", 32'(up_rack), 32'd0);
        slv_rack = 3'b101; slv_rdata[0 +: 32] = 32'h0000_00F0; slv_rdata[64 +: 32] = 32'h0000_000F; tick();
        slv_rack = '0;
        chk("fwd_or",    up_rdata,          32'h0000_00FF);
        chk("fwd_multi", 32'(up_multi_ack), 32'd1);
        tick();
        chk("fwd_sticky", 32'(up_multi_ack), 32'd1);
        up_status_clr = 1'b1; tick();
        up_status_clr = 1'b0;
        chk("fwd_clr", 32'(up_multi_ack), 32'd0);
        up_status_clr = 1'b1; slv_wack = 3'b011; tick();
        up_status_clr = 1'b0; slv_wack = '0;
        chk("fwd_clr_evt", 32'(up_multi_ack), 32'd1);
        chk("fwd_clr_wck", 32'(up_wack),      32'd1);
        up_rreq = 1'b1; up_raddr = 14'h0ABC; tick();
        up_rreq = 1'b0; racks = 0; run(12);
        chk("fwd_no_to",   32'(racks),           32'd0);
        chk("fwd_cnt",     32'(up_timeout_cnt),  32'd0);
        chk("fwd_addr",    32'(up_timeout_addr), 32'd0);
        chk("fwd_late",    32'(up_late_ack),     32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
